// File: rtl/semaforo_ctrl.sv
// Two-street traffic light controller with pedestrian requests.
// Sequences A green/yellow, all-red, B green/yellow, all-red. A latched
// pedestrian request may cut the current green short once the minimum
// green time has elapsed.
module semaforo_ctrl #(
    parameter int T_VERDE     = 20,
    parameter int T_VERDE_MIN = 5,
    parameter int T_AMARILLO  = 4,
    parameter int T_ROJO      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic       boton_a,
    input  logic       boton_b,
    output logic [1:0] semaforo_a,
    output logic [1:0] semaforo_b,
    output logic       pend_a,
    output logic       pend_b,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        A_VERDE    = 3'd0,
        A_AMARILLO = 3'd1,
        ROJO_1     = 3'd2,
        B_VERDE    = 3'd3,
        B_AMARILLO = 3'd4,
        ROJO_2     = 3'd5
    } state_t;

    localparam logic [1:0] LUZ_ROJO     = 2'b00;
    localparam logic [1:0] LUZ_AMARILLO = 2'b01;
    localparam logic [1:0] LUZ_VERDE    = 2'b10;

    // Counter values on which each phase ends (durations are 1-based).
    localparam logic [7:0] FIN_VERDE     = 8'(T_VERDE - 1);
    localparam logic [7:0] FIN_VERDE_MIN = 8'(T_VERDE_MIN - 1);
    localparam logic [7:0] FIN_AMARILLO  = 8'(T_AMARILLO - 1);
    localparam logic [7:0] FIN_ROJO      = 8'(T_ROJO - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_a_q, pend_a_d;
    logic       pend_b_q, pend_b_d;

    // Next state, phase counter and pedestrian latches.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_a_d = pend_a_q | (boton_a && (state_q != B_VERDE));
        pend_b_d = pend_b_q | (boton_b && (state_q != A_VERDE));

        case (state_q)
            A_VERDE: begin
                if (enb && ((cnt_q == FIN_VERDE) ||
                            (pend_a_q && (cnt_q >= FIN_VERDE_MIN))))
                    state_d = A_AMARILLO;
            end
            A_AMARILLO: begin
                if (enb && (cnt_q == FIN_AMARILLO))
                    state_d = ROJO_1;
            end
            ROJO_1: begin
                if (enb && (cnt_q == FIN_ROJO))
                    state_d = B_VERDE;
            end
            B_VERDE: begin
                if (enb && ((cnt_q == FIN_VERDE) ||
                            (pend_b_q && (cnt_q >= FIN_VERDE_MIN))))
                    state_d = B_AMARILLO;
            end
            B_AMARILLO: begin
                if (enb && (cnt_q == FIN_AMARILLO))
                    state_d = ROJO_2;
            end
            ROJO_2: begin
                if (enb && (cnt_q == FIN_ROJO))
                    state_d = A_VERDE;
            end
            default: state_d = ROJO_2;
        endcase

        if (state_d != state_q)
            cnt_d = 8'd0;
        else if (enb)
            cnt_d = cnt_q + 8'd1;

        if ((state_d == B_VERDE) && (state_q != B_VERDE))
            pend_a_d = 1'b0;
        if ((state_d == A_VERDE) && (state_q != A_VERDE))
            pend_b_d = 1'b0;
    end

    // State register; reset parks the controller in all-red.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ROJO_2;
            cnt_q    <= 8'd0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
        end
    end

    // Moore decode of the vehicular lights from the registered state.
    always_comb begin
        semaforo_a = LUZ_ROJO;
        semaforo_b = LUZ_ROJO;
        case (state_q)
            A_VERDE:    semaforo_a = LUZ_VERDE;
            A_AMARILLO: semaforo_a = LUZ_AMARILLO;
            B_VERDE:    semaforo_b = LUZ_VERDE;
            B_AMARILLO: semaforo_b = LUZ_AMARILLO;
            default: begin
                semaforo_a = LUZ_ROJO;
                semaforo_b = LUZ_ROJO;
            end
        endcase
    end

    assign estado = state_q;
    assign pend_a = pend_a_q;
    assign pend_b = pend_b_q;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Self-checking bench for semaforo_ctrl: a phase/elapsed-time model of the
// intersection is stepped alongside the DUT and compared every cycle, with
// hand-computed literal expectations at key cycles of a directed scenario.
module tb_semaforo_ctrl;

    localparam int T_V    = 20;
    localparam int T_VMIN = 5;
    localparam int T_AM   = 4;
    localparam int T_R    = 2;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       enb     = 1'b0;
    logic       boton_a = 1'b0;
    logic       boton_b = 1'b0;
    logic [1:0] semaforo_a;
    logic [1:0] semaforo_b;
    logic       pend_a;
    logic       pend_b;
    logic [2:0] estado;

    semaforo_ctrl #(
        .T_VERDE    (T_V),
        .T_VERDE_MIN(T_VMIN),
        .T_AMARILLO (T_AM),
        .T_ROJO     (T_R)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enb       (enb),
        .boton_a   (boton_a),
        .boton_b   (boton_b),
        .semaforo_a(semaforo_a),
        .semaforo_b(semaforo_b),
        .pend_a    (pend_a),
        .pend_b    (pend_b),
        .estado    (estado)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Model: phase 0..5 in cycle order, enabled cycles spent in it, requests.
    int dur[6]   = '{T_V, T_AM, T_R, T_V, T_AM, T_R};
    int luz_a[6] = '{2, 1, 0, 0, 0, 0};
    int luz_b[6] = '{0, 0, 0, 2, 1, 0};
    int m_phase;
    int m_elapsed;
    bit m_pa;
    bit m_pb;
    int g_cnt;

    task automatic compareValue(input string name, input int act, input int exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_phase   = 5;
        m_elapsed = 0;
        m_pa      = 1'b0;
        m_pb      = 1'b0;
        g_cnt     = 0;
    endtask

    task automatic modelStep(input bit en, input bit ba, input bit bb);
        bit leave;
        int p;
        p     = m_phase;
        leave = 1'b0;
        if (en) begin
            if (m_elapsed + 1 == dur[p])
                leave = 1'b1;
            if (((p == 0 && m_pa) || (p == 3 && m_pb)) && (m_elapsed + 1 >= T_VMIN))
                leave = 1'b1;
        end
        if (ba && p != 3) m_pa = 1'b1;
        if (bb && p != 0) m_pb = 1'b1;
        if (leave) begin
            m_phase   = (p + 1) % 6;
            m_elapsed = 0;
            if (m_phase == 3) m_pa = 1'b0;
            if (m_phase == 0) m_pb = 1'b0;
        end else if (en) begin
            m_elapsed++;
        end
    endtask

    task automatic checkOutput();
        compareValue("estado", int'(estado), m_phase);
        compareValue("semaforo_a", int'(semaforo_a), luz_a[m_phase]);
        compareValue("semaforo_b", int'(semaforo_b), luz_b[m_phase]);
        compareValue("pend_a", int'(pend_a), int'(m_pa));
        compareValue("pend_b", int'(pend_b), int'(m_pb));
        compareValue("enc11", int'(semaforo_a == 2'b11 || semaforo_b == 2'b11), 0);
        compareValue("conflicto", int'(semaforo_a != 2'b00 && semaforo_b != 2'b00), 0);
    endtask

    task automatic applyStimulus(input bit en, input bit ba, input bit bb);
        bit was_green;
        @(negedge clk);
        enb     = en;
        boton_a = ba;
        boton_b = bb;
        was_green = (semaforo_a == 2'b10) || (semaforo_b == 2'b10);
        @(posedge clk);
        modelStep(en, ba, bb);
        #1;
        if (was_green && en) g_cnt++;
        if (was_green && semaforo_a != 2'b10 && semaforo_b != 2'b10) begin
            compareValue("verde_min", int'(g_cnt >= T_VMIN), 1);
            g_cnt = 0;
        end
        checkOutput();
    endtask

    task automatic checkResetLiterals();
        compareValue("rst_estado", int'(estado), 5);
        compareValue("rst_sem_a", int'(semaforo_a), 0);
        compareValue("rst_sem_b", int'(semaforo_b), 0);
        compareValue("rst_pend_a", int'(pend_a), 0);
        compareValue("rst_pend_b", int'(pend_b), 0);
    endtask

    // Directed scenario, literal pins, mid-cycle reset, then random traffic.
    initial begin
        bit en, ba, bb;
        $display("[TB] semaforo_ctrl bench start");
        #3 reset = 1'b0;
        #1 checkResetLiterals();
        modelReset();
        repeat (2) begin
            @(posedge clk);
            #1 checkOutput();
        end
        reset = 1'b1;

        for (int k = 1; k <= 145; k++) begin
            ba = (k == 56) || (k == 102) || (k == 134);
            bb = (k == 133) || (k == 144);
            en = !(k >= 131 && k <= 137);
            applyStimulus(en, ba, bb);
            case (k)
                1:   compareValue("k1_estado", int'(estado), 5);
                2:   begin compareValue("k2_estado", int'(estado), 0);
                           compareValue("k2_sem_a", int'(semaforo_a), 2); end
                21:  compareValue("k21_estado", int'(estado), 0);
                22:  begin compareValue("k22_estado", int'(estado), 1);
                           compareValue("k22_sem_a", int'(semaforo_a), 1); end
                26:  compareValue("k26_estado", int'(estado), 2);
                28:  begin compareValue("k28_estado", int'(estado), 3);
                           compareValue("k28_sem_b", int'(semaforo_b), 2); end
                48:  compareValue("k48_estado", int'(estado), 4);
                52:  compareValue("k52_estado", int'(estado), 5);
                54:  compareValue("k54_estado", int'(estado), 0);
                56:  compareValue("k56_pend_a", int'(pend_a), 1);
                58:  compareValue("k58_estado", int'(estado), 0);
                59:  compareValue("k59_estado", int'(estado), 1);
                62:  compareValue("k62_estado", int'(estado), 1);
                63:  compareValue("k63_estado", int'(estado), 2);
                64:  compareValue("k64_pend_a", int'(pend_a), 1);
                65:  begin compareValue("k65_estado", int'(estado), 3);
                           compareValue("k65_pend_a", int'(pend_a), 0); end
                101: compareValue("k101_estado", int'(estado), 0);
                102: begin compareValue("k102_estado", int'(estado), 0);
                           compareValue("k102_pend_a", int'(pend_a), 1); end
                103: compareValue("k103_estado", int'(estado), 1);
                106: compareValue("k106_estado", int'(estado), 1);
                107: compareValue("k107_estado", int'(estado), 2);
                109: compareValue("k109_estado", int'(estado), 3);
                130: compareValue("k130_estado", int'(estado), 4);
                137: begin compareValue("k137_estado", int'(estado), 4);
                           compareValue("k137_sem_b", int'(semaforo_b), 1);
                           compareValue("k137_pend_b", int'(pend_b), 1);
                           compareValue("k137_pend_a", int'(pend_a), 1); end
                139: compareValue("k139_estado", int'(estado), 4);
                140: compareValue("k140_estado", int'(estado), 5);
                142: begin compareValue("k142_estado", int'(estado), 0);
                           compareValue("k142_pend_b", int'(pend_b), 0);
                           compareValue("k142_pend_a", int'(pend_a), 1); end
                144: compareValue("k144_pend_b", int'(pend_b), 0);
                145: compareValue("k145_estado", int'(estado), 0);
                default: ;
            endcase
        end

        #1 reset = 1'b0;
        #1 checkResetLiterals();
        modelReset();
        #1 reset = 1'b1;

        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (k == 1) compareValue("r1_estado", int'(estado), 5);
            if (k == 2) compareValue("r2_estado", int'(estado), 0);
        end

        for (int k = 0; k < 10000; k++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
